// File: rtl/flow_to_camera.sv
// Pixel flow to parallel camera stream: a line FIFO absorbs bursty input while a
// pclk-tick driven FSM replays frames with programmable size and blanking.
module flow_to_camera #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned PIXEL_WIDTH    = 8,
   parameter int unsigned FIFO_DEPTH     = 2048,
   parameter int unsigned PCLK_HALF      = 3,
   parameter int unsigned DEFAULT_SCR    = 0,
   parameter int unsigned DEFAULT_COLS   = 320,
   parameter int unsigned DEFAULT_ROWS   = 240,
   parameter int unsigned DEFAULT_VDELAY = 23,
   parameter int unsigned DEFAULT_HDELAY = 100
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [PIXEL_WIDTH-1:0] in_data,
   input  logic                   in_dv,
   input  logic                   in_fv,
   input  logic                   in_sop,
   input  logic                   in_eop,
   output logic                   pclk_o,
   output logic                   vsync_o,
   output logic                   href_o,
   output logic [PIXEL_WIDTH-1:0] pixel_o,
   input  logic [2:0]             addr_rel_i,
   input  logic                   wr_i,
   input  logic [DATA_WIDTH-1:0]  datawr_i,
   input  logic                   rd_i,
   output logic [DATA_WIDTH-1:0]  datard_o
);
   localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LVL_W   = PTR_W + 1;
   localparam int unsigned DIV_MAX = 2 * PCLK_HALF - 1;
   localparam int unsigned DIV_W   = $clog2(2 * PCLK_HALF);

   typedef enum logic [2:0] {S_IDLE, S_VPRE, S_VBLANK, S_LINE, S_HGAP, S_VPOST} state_e;

   state_e                  state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic                    pclk_q, pclk_d;
   logic [PIXEL_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]        level_q, level_d;
   logic                    armed_q, armed_d, ovf_q, ovf_d, enable_q, enable_d;
   logic [15:0]             cols_q, cols_d, rows_q, rows_d, vdel_q, vdel_d, hdel_q, hdel_d;
   logic [15:0]             sh_cols_q, sh_cols_d, sh_rows_q, sh_rows_d;
   logic [15:0]             sh_vdel_q, sh_vdel_d, sh_hdel_q, sh_hdel_d;
   logic [15:0]             cnt_q, cnt_d, line_q, line_d;
   logic                    vsync_q, vsync_d, href_q, href_d;
   logic [PIXEL_WIDTH-1:0]  pixel_q, pixel_d;
   logic [DATA_WIDTH-1:0]   datard_q, datard_d, status_c;
   logic                    tick_c, full_c, arm_c, want_c, push_c, pop_c, ovf_clr_c;
   logic                    unused_c;

   assign unused_c = ^{in_fv, in_eop, datawr_i[DATA_WIDTH-1:16]};

   // Delay of 0 behaves like 1: index of the last tick spent in a timed state.
   function automatic logic [15:0] last_tick(input logic [15:0] n);
      return (n == 16'd0) ? 16'd0 : n - 16'd1;
   endfunction

   // Divider, input acceptance, register writes and read-back.
   always_comb begin
      tick_c    = (div_q == DIV_W'(DIV_MAX));
      div_d     = tick_c ? '0 : div_q + DIV_W'(1);
      pclk_d    = (32'(div_d) >= PCLK_HALF);

      full_c    = (level_q == LVL_W'(FIFO_DEPTH));
      arm_c     = in_dv & in_sop & enable_q & ~full_c;
      want_c    = in_dv & (armed_q | arm_c);
      push_c    = want_c & ~full_c;
      armed_d   = enable_q & (armed_q | arm_c);
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_c);

      enable_d  = enable_q;
      ovf_clr_c = 1'b0;
      cols_d    = cols_q;
      rows_d    = rows_q;
      vdel_d    = vdel_q;
      hdel_d    = hdel_q;
      if (wr_i) begin
         case (addr_rel_i)
            3'd0: begin
               enable_d  = datawr_i[0];
               ovf_clr_c = datawr_i[1];
            end
            3'd1:    cols_d = datawr_i[15:0];
            3'd2:    rows_d = datawr_i[15:0];
            3'd3:    vdel_d = datawr_i[15:0];
            3'd4:    hdel_d = datawr_i[15:0];
            default: ;
         endcase
      end
      // A drop in the same cycle as the clear keeps the flag set.
      ovf_d = (want_c & full_c) | (ovf_q & ~ovf_clr_c);

      status_c        = '0;
      status_c[0]     = (state_q != S_IDLE);
      status_c[1]     = ovf_q;
      status_c[27:16] = 12'(level_q);

      datard_d = datard_q;
      if (rd_i) begin
         case (addr_rel_i)
            3'd0:    datard_d = DATA_WIDTH'(enable_q);
            3'd1:    datard_d = DATA_WIDTH'(cols_q);
            3'd2:    datard_d = DATA_WIDTH'(rows_q);
            3'd3:    datard_d = DATA_WIDTH'(vdel_q);
            3'd4:    datard_d = DATA_WIDTH'(hdel_q);
            3'd5:    datard_d = status_c;
            default: datard_d = '0;
         endcase
      end
   end

   // Frame timing FSM; only advances on the tick where pclk falls.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      line_d    = line_q;
      sh_cols_d = sh_cols_q;
      sh_rows_d = sh_rows_q;
      sh_vdel_d = sh_vdel_q;
      sh_hdel_d = sh_hdel_q;
      pop_c     = 1'b0;
      if (tick_c) begin
         case (state_q)
            S_IDLE: begin
               if (enable_q && cols_q != 16'd0 && rows_q != 16'd0 &&
                   32'(level_q) >= 32'(cols_q)) begin
                  sh_cols_d = cols_q;
                  sh_rows_d = rows_q;
                  sh_vdel_d = vdel_q;
                  sh_hdel_d = hdel_q;
                  line_d    = '0;
                  cnt_d     = '0;
                  state_d   = S_VPRE;
               end
            end
            S_VPRE: begin
               if (cnt_q == last_tick(sh_vdel_q)) begin
                  cnt_d   = '0;
                  state_d = S_VBLANK;
               end else cnt_d = cnt_q + 16'd1;
            end
            S_VBLANK: begin
               if (cnt_q == last_tick(sh_hdel_q)) begin
                  cnt_d   = '0;
                  pop_c   = 1'b1;
                  state_d = S_LINE;
               end else cnt_d = cnt_q + 16'd1;
            end
            S_LINE: begin
               if (cnt_q == sh_cols_q - 16'd1) begin
                  cnt_d   = '0;
                  line_d  = line_q + 16'd1;
                  state_d = S_HGAP;
               end else begin
                  cnt_d = cnt_q + 16'd1;
                  pop_c = 1'b1;
               end
            end
            S_HGAP: begin
               // Counter parks at its last value while waiting for a full line.
               if (cnt_q == last_tick(sh_hdel_q)) begin
                  if (line_q == sh_rows_q) begin
                     cnt_d   = '0;
                     state_d = S_VPOST;
                  end else if (32'(level_q) >= 32'(sh_cols_q)) begin
                     cnt_d   = '0;
                     pop_c   = 1'b1;
                     state_d = S_LINE;
                  end
               end else cnt_d = cnt_q + 16'd1;
            end
            S_VPOST: begin
               if (cnt_q == last_tick(sh_vdel_q)) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else cnt_d = cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
         endcase
      end
      vsync_d  = (state_d == S_VBLANK) || (state_d == S_LINE) ||
                 (state_d == S_HGAP) || (state_d == S_VPOST);
      href_d   = (state_d == S_LINE);
      pixel_d  = pop_c ? mem_q[rd_ptr_q] : pixel_q;
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
      level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
   end

   always_ff @(posedge clk_i) begin
      if (push_c) mem_q[wr_ptr_q] <= in_data;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         pclk_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         armed_q   <= 1'b0;
         ovf_q     <= 1'b0;
         enable_q  <= 1'(DEFAULT_SCR);
         cols_q    <= 16'(DEFAULT_COLS);
         rows_q    <= 16'(DEFAULT_ROWS);
         vdel_q    <= 16'(DEFAULT_VDELAY);
         hdel_q    <= 16'(DEFAULT_HDELAY);
         sh_cols_q <= '0;
         sh_rows_q <= '0;
         sh_vdel_q <= '0;
         sh_hdel_q <= '0;
         cnt_q     <= '0;
         line_q    <= '0;
         vsync_q   <= 1'b0;
         href_q    <= 1'b0;
         pixel_q   <= '0;
         datard_q  <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         pclk_q    <= pclk_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         armed_q   <= armed_d;
         ovf_q     <= ovf_d;
         enable_q  <= enable_d;
         cols_q    <= cols_d;
         rows_q    <= rows_d;
         vdel_q    <= vdel_d;
         hdel_q    <= hdel_d;
         sh_cols_q <= sh_cols_d;
         sh_rows_q <= sh_rows_d;
         sh_vdel_q <= sh_vdel_d;
         sh_hdel_q <= sh_hdel_d;
         cnt_q     <= cnt_d;
         line_q    <= line_d;
         vsync_q   <= vsync_d;
         href_q    <= href_d;
         pixel_q   <= pixel_d;
         datard_q  <= datard_d;
      end
   end

   assign pclk_o   = pclk_q;
   assign vsync_o  = vsync_q;
   assign href_o   = href_q;
   assign pixel_o  = pixel_q;
   assign datard_o = datard_q;

endmodule

// File: tb/tb_flow_to_camera.sv
// Randomized bench for flow_to_camera: frame shape and pixel order are checked
// per pclk period against a pixel queue and the programmed timing.
module tb_flow_to_camera;
   localparam int unsigned PW = 8;
   localparam int unsigned DW = 32;

   logic          clk_i = 1'b0;
   logic          reset_n_i = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          in_dv = 1'b0, in_fv = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic          pclk_o, vsync_o, href_o;
   logic [PW-1:0] pixel_o;
   logic [2:0]    addr_rel_i = '0;
   logic          wr_i = 1'b0, rd_i = 1'b0;
   logic [DW-1:0] datawr_i = '0;
   logic [DW-1:0] datard_o;

   flow_to_camera #(.FIFO_DEPTH(16), .PCLK_HALF(3)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .in_data(in_data), .in_dv(in_dv), .in_fv(in_fv), .in_sop(in_sop), .in_eop(in_eop),
      .pclk_o(pclk_o), .vsync_o(vsync_o), .href_o(href_o), .pixel_o(pixel_o),
      .addr_rel_i(addr_rel_i), .wr_i(wr_i), .datawr_i(datawr_i),
      .rd_i(rd_i), .datard_o(datard_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int n_chk = 0, n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   // Per-pclk-period observation of the camera stream, sampled after the pclk rise.
   int            line_q[$], gap_q[$], lead_q[$], tail_q[$];
   logic [PW-1:0] obs_pix[$];
   int            frames = 0, hi_len = 0, lo_len = 0;
   logic          p_vs = 1'b0, p_href = 1'b0;
   bit            seen_line = 1'b0;

   always @(posedge pclk_o) begin
      #1;
      if (vsync_o && !p_vs) begin
         lo_len    = 0;
         seen_line = 1'b0;
      end
      if (href_o) begin
         if (!p_href) begin
            if (seen_line) gap_q.push_back(lo_len);
            else lead_q.push_back(lo_len);
            seen_line = 1'b1;
            hi_len    = 0;
         end
         hi_len++;
         obs_pix.push_back(pixel_o);
      end else begin
         if (p_href) begin
            line_q.push_back(hi_len);
            lo_len = 0;
         end
         if (vsync_o) lo_len++;
      end
      if (!vsync_o && p_vs) begin
         tail_q.push_back(lo_len);
         frames++;
      end
      p_vs   = vsync_o;
      p_href = href_o;
   end

   // Reference: every accepted pixel must reappear, in order, inside href.
   logic [PW-1:0] exp_pix[$];
   int lb = 0, gb = 0, ldb = 0, tlb = 0, pb = 0, nf = 0;

   task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk_i);
      addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
      @(negedge clk_i);
      wr_i = 1'b0;
   endtask

   task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk_i);
      addr_rel_i = a; rd_i = 1'b1;
      @(negedge clk_i);
      rd_i = 1'b0;
      d = datard_o;
   endtask

   task automatic push_px(input logic [PW-1:0] v, input logic sop, input logic eop);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      in_data = v; in_dv = 1'b1; in_sop = sop; in_eop = eop; in_fv = 1'b1;
      @(negedge clk_i);
      in_dv = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic push_frame(input int n, input bit seq, input bit model);
      for (int i = 0; i < n; i++) begin
         logic [PW-1:0] v;
         v = seq ? PW'(i) : PW'($urandom);
         push_px(v, 1'(i == 0), 1'(i == n - 1));
         if (model) exp_pix.push_back(v);
      end
      in_fv = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int target);
      for (int i = 0; i < 5000 && frames < target; i++) @(negedge clk_i);
      check_eq({tag, " frame_done"}, 32'(frames), 32'(target));
   endtask

   task automatic wait_href(input string tag);
      for (int i = 0; i < 3000 && !href_o; i++) @(negedge clk_i);
      check_eq({tag, " href_seen"}, 32'(href_o), 32'd1);
   endtask

   task automatic check_frame(input string tag, input int ncols, input int nrows,
                              input int h, input int v, input bit exact_gap);
      int hh, vv, n;
      hh = (h == 0) ? 1 : h;
      vv = (v == 0) ? 1 : v;
      check_eq({tag, " line_count"}, 32'(line_q.size() - lb), 32'(nrows));
      for (int i = lb; i < line_q.size(); i++)
         check_eq({tag, " line_len"}, 32'(line_q[i]), 32'(ncols));
      check_eq({tag, " gap_count"}, 32'(gap_q.size() - gb), 32'(nrows - 1));
      for (int i = gb; i < gap_q.size(); i++) begin
         if (exact_gap) check_eq({tag, " hgap"}, 32'(gap_q[i]), 32'(hh));
         else check_eq({tag, " hgap_stretched"}, 32'(gap_q[i] > hh), 32'd1);
      end
      check_eq({tag, " vsync_to_href"}, (lead_q.size() > ldb) ? 32'(lead_q[ldb]) : 32'hFFFF_FFFF, 32'(hh));
      check_eq({tag, " href_to_vsync_fall"}, (tail_q.size() > tlb) ? 32'(tail_q[tlb]) : 32'hFFFF_FFFF, 32'(hh + vv));
      check_eq({tag, " pixel_count"}, 32'(obs_pix.size() - pb), 32'(exp_pix.size()));
      n = obs_pix.size() - pb;
      if (exp_pix.size() < n) n = exp_pix.size();
      for (int i = 0; i < n; i++)
         check_eq({tag, " pixel"}, 32'(obs_pix[pb + i]), 32'(exp_pix[i]));
      exp_pix.delete();
      lb = line_q.size(); gb = gap_q.size(); ldb = lead_q.size();
      tlb = tail_q.size(); pb = obs_pix.size();
   endtask

   initial begin
      logic [31:0] rd;
      int rise[$], fall[$];
      logic prev;
      int hi;

      // Reset state and divider shape
      repeat (3) @(negedge clk_i);
      check_eq("rst pclk", 32'(pclk_o), 32'd0);
      check_eq("rst vsync", 32'(vsync_o), 32'd0);
      check_eq("rst href", 32'(href_o), 32'd0);
      check_eq("rst pixel", 32'(pixel_o), 32'd0);
      check_eq("rst datard", datard_o, 32'd0);
      reset_n_i = 1'b1;
      prev = pclk_o;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (pclk_o && !prev) rise.push_back(i);
         if (!pclk_o && prev) fall.push_back(i);
         prev = pclk_o;
      end
      check_eq("pclk_period", (rise.size() >= 2) ? 32'(rise[1] - rise[0]) : 32'hFFFF_FFFF, 32'd6);
      hi = -1;
      foreach (fall[i]) if (hi < 0 && rise.size() > 0 && fall[i] > rise[0]) hi = fall[i] - rise[0];
      check_eq("pclk_high", 32'(hi), 32'd3);
      reg_rd(3'd1, rd); check_eq("rst cols", rd, 32'd320);
      reg_rd(3'd2, rd); check_eq("rst rows", rd, 32'd240);
      reg_rd(3'd3, rd); check_eq("rst vdelay", rd, 32'd23);
      reg_rd(3'd4, rd); check_eq("rst hdelay", rd, 32'd100);
      reg_rd(3'd0, rd); check_eq("rst scr", rd, 32'd0);
      reg_wr(3'd6, 32'hDEAD_BEEF);
      reg_rd(3'd6, rd); check_eq("rd addr6", rd, 32'd0);
      repeat (4) @(negedge clk_i);
      check_eq("datard_hold", datard_o, 32'd0);

      // Basic frame 0..15
      reg_wr(3'd1, 32'd8); reg_wr(3'd2, 32'd2);
      reg_wr(3'd3, 32'd3); reg_wr(3'd4, 32'd4);
      reg_wr(3'd0, 32'd1);
      push_frame(16, 1'b1, 1'b1);
      nf++; wait_frames("t2", nf);
      check_frame("t2", 8, 2, 4, 3, 1'b1);

      // Disarm, then junk before sop must vanish silently
      reg_wr(3'd0, 32'd0); reg_wr(3'd0, 32'd1);
      for (int i = 0; i < 5; i++) push_px(PW'(i), 1'b0, 1'b0);
      push_frame(16, 1'b0, 1'b1);
      nf++; wait_frames("t3", nf);
      check_frame("t3", 8, 2, 4, 3, 1'b1);
      reg_rd(3'd5, rd); check_eq("t3 status", rd, 32'd0);

      // Late second line stretches HGAP
      push_frame(8, 1'b0, 1'b1);
      repeat (24 * 6) @(negedge clk_i);
      push_frame(8, 1'b0, 1'b1);
      nf++; wait_frames("t4", nf);
      check_frame("t4", 8, 2, 4, 3, 1'b0);

      // cols written mid-frame only affects the next frame
      push_frame(16, 1'b0, 1'b1);
      wait_href("t6");
      reg_wr(3'd1, 32'd4);
      nf++; wait_frames("t6a", nf);
      check_frame("t6a", 8, 2, 4, 3, 1'b1);
      push_frame(8, 1'b0, 1'b1);
      nf++; wait_frames("t6b", nf);
      check_frame("t6b", 4, 2, 4, 3, 1'b1);
      reg_rd(3'd1, rd); check_eq("t6 cols", rd, 32'd4);

      // Overflow: FSM held off by oversize cols, 20 pushes into 16 entries
      reg_wr(3'd1, 32'd100);
      push_frame(20, 1'b0, 1'b0);
      reg_rd(3'd5, rd); check_eq("t5 status_ovf", rd, 32'h0010_0002);
      reg_wr(3'd0, 32'd3);
      reg_rd(3'd5, rd); check_eq("t5 status_clr", rd, 32'h0010_0000);
      reg_rd(3'd0, rd); check_eq("t5 enable_kept", rd, 32'd1);

      // Reset mid-line clears outputs immediately
      reg_wr(3'd1, 32'd8);
      wait_href("t7");
      repeat ($urandom_range(1, 5)) @(negedge clk_i);
      reset_n_i = 1'b0;
      #1;
      check_eq("t7 href_rst", 32'(href_o), 32'd0);
      check_eq("t7 vsync_rst", 32'(vsync_o), 32'd0);
      check_eq("t7 pixel_rst", 32'(pixel_o), 32'd0);
      check_eq("t7 pclk_rst", 32'(pclk_o), 32'd0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      reg_rd(3'd5, rd); check_eq("t7 status", rd, 32'd0);
      reg_rd(3'd1, rd); check_eq("t7 cols", rd, 32'd320);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
